// File: rtl/controlador_pkg.sv
// controlador_pkg: shared types, default sizes and helpers for the
// programmable count-sequence controller.
//   stateT  - controller states (IDLE, RUN, PAUSE, DONE)
//   DEF_*   - default table depth, value width and pass-counter width
//   effLen  - effective sequence length derived from the LEN input
package controlador_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } stateT;

  localparam int DEF_DEPTH = 8;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_NW    = 4;

  // Out-of-range lengths (0 or above the table depth) fall back to the
  // full table, so a mis-programmed LEN still produces a usable sequence.
  function automatic int effLen(input int len, input int depth);
    if (len >= 1 && len <= depth) begin
      return len;
    end
    return depth;
  endfunction

endpackage

// File: rtl/tabla_secuencia.sv
// tabla_secuencia: DEPTH x WIDTH register file holding the count sequence.
//   clk  - clock
//   srst - synchronous clear of every entry
//   we   - write enable (already qualified by the controller state)
//   wa   - write address
//   wd   - write data
//   ra   - read address (combinational read)
//   rd   - read data
module tabla_secuencia #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 4,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] wd,
  input  logic [AW-1:0]    ra,
  output logic [WIDTH-1:0] rd
);

  logic [DEPTH-1:0][WIDTH-1:0] entries;

  // One register per entry; the read mux sits in front of the controller's
  // Q register, so a write and a read on the same edge see the old value.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : gEntry
      logic [WIDTH-1:0] entryReg;

      always_ff @(posedge clk) begin
        if (srst) begin
          entryReg <= '0;
        end else if (we && (wa == AW'(gi))) begin
          entryReg <= wd;
        end
      end

      assign entries[gi] = entryReg;
    end
  endgenerate

  assign rd = entries[ra];

endmodule

// File: rtl/controlador_secuencia.sv
// controlador_secuencia: steps through a programmable table of count values,
// replacing hard-wired counter next-state logic.
//   C     - clock, rising edge
//   R     - synchronous active-high reset (also clears the table)
//   WE/WA/WD - table write port, accepted only in IDLE or DONE
//   LEN/NCYC/DIR - length, pass count (0 = endless) and direction,
//                  sampled only when a run is started
//   START/STOP/STEP - run control, priority STOP > START > STEP
//   Q/IDX - current count value and table index (registered)
//   TC    - Q shows the last entry of a pass
//   BUSY  - RUN or PAUSE;  DONE - run finished
//   WERR  - one-cycle pulse when a write is rejected
module controlador_secuencia
  import controlador_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW    = 3,
  parameter int NW    = DEF_NW
) (
  input  logic             C,
  input  logic             R,
  input  logic             WE,
  input  logic [AW-1:0]    WA,
  input  logic [WIDTH-1:0] WD,
  input  logic [AW:0]      LEN,
  input  logic [NW-1:0]    NCYC,
  input  logic             DIR,
  input  logic             START,
  input  logic             STOP,
  input  logic             STEP,
  output logic [WIDTH-1:0] Q,
  output logic [AW-1:0]    IDX,
  output logic             TC,
  output logic             BUSY,
  output logic             DONE,
  output logic             WERR
);

  stateT            stateReg, stateNext;
  logic [AW-1:0]    idxReg, idxNext;
  logic [WIDTH-1:0] qReg;
  logic             tcReg, tcNext;
  logic [NW-1:0]    passReg, passNext;
  logic [AW:0]      lenReg, lenNext;
  logic [NW-1:0]    ncycReg, ncycNext;
  logic             dirReg, dirNext;
  logic             busyReg, doneReg, werrReg;

  logic             loadQ, clearQ;
  logic             doStart, doAdvance, doAbort;
  logic [WIDTH-1:0] tblRd;
  logic             tblWe;

  // Values that a START would latch, derived from the live inputs.
  logic [AW:0]      startLen;
  logic [AW-1:0]    startFirst, startLast;

  // Sequence bounds for the run in progress, from the latched settings.
  logic [AW-1:0]    firstIdx, lastIdx, stepIdx;
  logic [NW-1:0]    passInc;

  assign startLen   = (AW+1)'(effLen(int'(LEN), DEPTH));
  assign startFirst = DIR ? AW'(startLen - (AW+1)'(1)) : '0;
  assign startLast  = DIR ? '0 : AW'(startLen - (AW+1)'(1));

  assign firstIdx = dirReg ? AW'(lenReg - (AW+1)'(1)) : '0;
  assign lastIdx  = dirReg ? '0 : AW'(lenReg - (AW+1)'(1));
  assign stepIdx  = dirReg ? (idxReg - AW'(1)) : (idxReg + AW'(1));
  assign passInc  = passReg + NW'(1);

  // Writes are only safe while the table is not being traversed.
  assign tblWe = WE && ((stateReg == ST_IDLE) || (stateReg == ST_DONE));

  always_comb begin
    stateNext = stateReg;
    idxNext   = idxReg;
    tcNext    = tcReg;
    passNext  = passReg;
    lenNext   = lenReg;
    ncycNext  = ncycReg;
    dirNext   = dirReg;
    loadQ     = 1'b0;
    clearQ    = 1'b0;
    doStart   = 1'b0;
    doAdvance = 1'b0;
    doAbort   = 1'b0;

    case (stateReg)
      ST_IDLE: begin
        if (START) doStart = 1'b1;
      end
      ST_RUN: begin
        if (STOP) stateNext = ST_PAUSE;
        else      doAdvance = 1'b1;
      end
      ST_PAUSE: begin
        if (STOP)       doAbort   = 1'b1;
        else if (START) stateNext = ST_RUN;   // first advance on the next edge
        else if (STEP)  doAdvance = 1'b1;
      end
      ST_DONE: begin
        if (STOP)       doAbort = 1'b1;
        else if (START) doStart = 1'b1;
      end
      default: stateNext = ST_IDLE;
    endcase

    if (doStart) begin
      stateNext = ST_RUN;
      lenNext   = startLen;
      ncycNext  = NCYC;
      dirNext   = DIR;
      passNext  = '0;
      idxNext   = startFirst;
      tcNext    = (startFirst == startLast);
      loadQ     = 1'b1;
    end

    if (doAbort) begin
      stateNext = ST_IDLE;
      idxNext   = '0;
      tcNext    = 1'b0;
      clearQ    = 1'b1;
    end

    if (doAdvance) begin
      if (idxReg == lastIdx) begin
        if ((ncycReg != '0) && (passInc == ncycReg)) begin
          // Final pass finished: hold on the last entry, TC stays high.
          stateNext = ST_DONE;
        end else begin
          // Saturate so endless mode never wraps the counter.
          passNext = (&passReg) ? passReg : passInc;
          idxNext  = firstIdx;
          tcNext   = (firstIdx == lastIdx);
          loadQ    = 1'b1;
        end
      end else begin
        idxNext = stepIdx;
        tcNext  = (stepIdx == lastIdx);
        loadQ   = 1'b1;
      end
    end
  end

  // Reading at the next index lets Q and IDX update on the same edge.
  tabla_secuencia #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) uTabla (
    .clk  (C),
    .srst (R),
    .we   (tblWe),
    .wa   (WA),
    .wd   (WD),
    .ra   (idxNext),
    .rd   (tblRd)
  );

  always_ff @(posedge C) begin
    if (R) begin
      stateReg <= ST_IDLE;
      idxReg   <= '0;
      qReg     <= '0;
      tcReg    <= 1'b0;
      passReg  <= '0;
      lenReg   <= '0;
      ncycReg  <= '0;
      dirReg   <= 1'b0;
      busyReg  <= 1'b0;
      doneReg  <= 1'b0;
      werrReg  <= 1'b0;
    end else begin
      stateReg <= stateNext;
      idxReg   <= idxNext;
      tcReg    <= tcNext;
      passReg  <= passNext;
      lenReg   <= lenNext;
      ncycReg  <= ncycNext;
      dirReg   <= dirNext;
      if (clearQ)     qReg <= '0;
      else if (loadQ) qReg <= tblRd;
      busyReg  <= (stateNext == ST_RUN) || (stateNext == ST_PAUSE);
      doneReg  <= (stateNext == ST_DONE);
      werrReg  <= WE && ((stateReg == ST_RUN) || (stateReg == ST_PAUSE));
    end
  end

  assign Q    = qReg;
  assign IDX  = idxReg;
  assign TC   = tcReg;
  assign BUSY = busyReg;
  assign DONE = doneReg;
  assign WERR = werrReg;

endmodule

// File: tb/tb_controlador_secuencia.sv
module tb_controlador_secuencia;

  logic       C = 1'b0;
  logic       R = 1'b0;
  logic       WE = 1'b0;
  logic [2:0] WA = '0;
  logic [3:0] WD = '0;
  logic [3:0] LEN = '0;
  logic [3:0] NCYC = '0;
  logic       DIR = 1'b0;
  logic       START = 1'b0;
  logic       STOP = 1'b0;
  logic       STEP = 1'b0;
  logic [3:0] Q;
  logic [2:0] IDX;
  logic       TC, BUSY, DONE, WERR;

  int total = 0;
  int bad   = 0;

  int tblVals[8] = '{3, 7, 1, 9, 0, 0, 0, 0};
  int seqUp[4]   = '{3, 7, 1, 9};
  int seqDn[4]   = '{9, 1, 7, 3};

  controlador_secuencia dut (
    .C     (C),
    .R     (R),
    .WE    (WE),
    .WA    (WA),
    .WD    (WD),
    .LEN   (LEN),
    .NCYC  (NCYC),
    .DIR   (DIR),
    .START (START),
    .STOP  (STOP),
    .STEP  (STEP),
    .Q     (Q),
    .IDX   (IDX),
    .TC    (TC),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .WERR  (WERR)
  );

  always #5 C = ~C;

  task automatic tick();
    @(posedge C);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("check %-12s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // RUN -> PAUSE -> IDLE using two STOP edges.
  task automatic goIdle();
    STOP = 1'b1;
    tick();
    tick();
    STOP = 1'b0;
  endtask

  // Start an endless ascending run with the given LEN and check nine values,
  // which exercises the wrap from index 7 back to 0.
  task automatic runFull(input logic [3:0] lenVal, input string tag);
    LEN = lenVal; NCYC = 4'd0; DIR = 1'b0; START = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick();
      START = 1'b0;
      chk({tag, "_q"},   Q,   tblVals[k % 8]);
      chk({tag, "_idx"}, IDX, k % 8);
      chk({tag, "_tc"},  TC,  (k == 7) ? 1 : 0);
    end
  endtask

  initial begin
    // Reset state
    R = 1'b1;
    tick();
    R = 1'b0;
    chk("rst_q", Q, 0);
    chk("rst_idx", IDX, 0);
    chk("rst_tc", TC, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_werr", WERR, 0);

    // Load table in IDLE
    for (int i = 0; i < 8; i++) begin
      WE = 1'b1; WA = 3'(i); WD = 4'(tblVals[i]);
      tick();
    end
    WE = 1'b0;
    chk("wr_werr", WERR, 0);

    // Ascending, two passes
    LEN = 4'd4; NCYC = 4'd2; DIR = 1'b0; START = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      START = 1'b0;
      chk("t1_q", Q, seqUp[k % 4]);
      chk("t1_tc", TC, (k % 4 == 3) ? 1 : 0);
      if (k == 0) chk("t1_busy", BUSY, 1);
    end
    tick();
    chk("t1_done", DONE, 1);
    chk("t1_busy_end", BUSY, 0);
    chk("t1_q_hold", Q, 9);
    chk("t1_tc_hold", TC, 1);
    tick();
    chk("t1_q_hold2", Q, 9);

    // Descending, one pass
    LEN = 4'd4; NCYC = 4'd1; DIR = 1'b1; START = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      START = 1'b0;
      chk("t2_q", Q, seqDn[k]);
      chk("t2_idx", IDX, 3 - k);
      chk("t2_tc", TC, (k == 3) ? 1 : 0);
    end
    tick();
    chk("t2_done", DONE, 1);
    chk("t2_q_hold", Q, 3);
    chk("t2_tc_hold", TC, 1);

    // Endless mode, then pause / step / resume
    LEN = 4'd4; NCYC = 4'd0; DIR = 1'b0; START = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      START = 1'b0;
      chk("t3_q", Q, seqUp[k % 4]);
      chk("t3_done", DONE, 0);
    end
    tick();
    chk("t3_q_pre", Q, 1);
    STOP = 1'b1;
    tick();
    STOP = 1'b0;
    chk("t3_pause_q", Q, 1);
    chk("t3_pause_busy", BUSY, 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t3_hold_q", Q, 1);
    end
    STEP = 1'b1;
    tick();
    STEP = 1'b0;
    chk("t3_step_q", Q, 9);
    chk("t3_step_tc", TC, 1);
    tick();
    chk("t3_step_hold", Q, 9);
    START = 1'b1;
    tick();
    START = 1'b0;
    chk("t3_resume_q", Q, 9);
    chk("t3_resume_bsy", BUSY, 1);
    tick();
    chk("t3_adv_q", Q, 3);
    chk("t3_adv_tc", TC, 0);

    // Write rejected during RUN
    WE = 1'b1; WA = 3'd0; WD = 4'd5;
    tick();
    WE = 1'b0;
    chk("t4_werr", WERR, 1);
    chk("t4_q", Q, 7);
    tick();
    chk("t4_werr_off", WERR, 0);
    chk("t4_q2", Q, 1);
    goIdle();
    chk("t4_idle_q", Q, 0);
    chk("t4_idle_idx", IDX, 0);
    chk("t4_idle_tc", TC, 0);
    chk("t4_idle_busy", BUSY, 0);
    LEN = 4'd4; NCYC = 4'd0; DIR = 1'b0; START = 1'b1;
    tick();
    START = 1'b0;
    chk("t4_tbl0", Q, 3);

    // Out-of-range lengths use the whole table
    goIdle();
    runFull(4'd0, "t5_len0");
    goIdle();
    runFull(4'd12, "t5_len12");

    // Reset mid-run
    tick();
    chk("t6_pre_q", Q, 7);
    R = 1'b1;
    tick();
    R = 1'b0;
    chk("t6_q", Q, 0);
    chk("t6_idx", IDX, 0);
    chk("t6_busy", BUSY, 0);
    chk("t6_tc", TC, 0);
    LEN = 4'd4; NCYC = 4'd0; DIR = 1'b0; START = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      START = 1'b0;
      chk("t6_clr_q", Q, 0);
      chk("t6_clr_idx", IDX, k);
      chk("t6_clr_busy", BUSY, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/controlador_secuencia.md
Name: controlador_secuencia

Overview:
Sequencer/controller for the arbitrary-sequence 4-bit counter datapath. It holds a programmable table of count values and steps through it on clock C, with these controls:
- Run, pause and single-step.
- Up/down traversal.
- A bounded or endless number of passes.
- A terminal-count pulse.

It replaces hard-wired JK next-state logic: the sequence becomes writable at runtime, and downstream logic sees the same Q bus it sees today.

Parameters:
DEPTH, 8, number of table entries (power of 2, 2..16)
WIDTH, 4, width of each count value / Q
AW, 3, table address width = log2(DEPTH)
NW, 4, width of the pass-count input/counter

Ports:
C  input  1  clock, rising-edge active
R  input  1  reset, synchronous, active-high
WE  input  1  table write strobe
WA  input  AW  table write address
WD  input  WIDTH  table write data
LEN  input  AW+1  active sequence length, sampled at START
NCYC  input  NW  passes to run, sampled at START; 0 = endless
DIR  input  1  0 = ascending index, 1 = descending; sampled at START
START  input  1  start (IDLE/DONE) or resume (PAUSE)
STOP  input  1  pause (RUN) or abort (PAUSE)
STEP  input  1  single advance while PAUSE
Q  output  WIDTH  current count value (registered)
IDX  output  AW  current table index (registered)
TC  output  1  high while Q shows the last entry of a pass
BUSY  output  1  high in RUN or PAUSE
DONE  output  1  high in DONE
WERR  output  1  one-cycle pulse: write rejected

Behaviour:
- Control is synchronous to C. Reset is synchronous, active-high, and all controls are sampled on the rising edge.
- On R=1 at an edge:
  - State = IDLE.
  - Q=0, IDX=0, TC=0, BUSY=0, DONE=0, WERR=0.
  - All table entries = 0.
  - Pass counter = 0.
  - R overrides everything, including a run in progress.
- Control priority: R > STOP > START > STEP. WE is independent of these controls.
- Effective length L: L = LEN if 1 <= LEN <= DEPTH, else L = DEPTH.
- Entry index:
  - First index F = 0 (DIR=0) or L-1 (DIR=1).
  - Last index E = L-1 (DIR=0) or 0 (DIR=1).
- Advance rule:
  - IDX <= IDX+1 (DIR=0) or IDX-1 (DIR=1), modulo L: E wraps to F.
  - Q <= tbl[new IDX] on the same edge. Q and IDX change together, with no extra latency.
- TC is registered and equals (IDX == E) in RUN/PAUSE/DONE. It is 0 in IDLE.
- States:
  - IDLE:
    - START -> RUN. At that edge: latch L, NCYC and DIR; IDX<=F; Q<=tbl[F]; pass counter <= 0.
    - STEP and STOP are ignored.
  - RUN: advances every cycle.
    - When advancing from E: pass counter +1.
    - If NCYC != 0 and the pass just completed is pass NCYC: go to DONE instead of advancing. IDX/Q hold at E, TC stays 1.
    - STOP -> PAUSE. IDX/Q hold and no advance occurs that edge.
  - PAUSE: IDX/Q hold.
    - START -> RUN, with the first advance on the following edge.
    - STEP performs exactly one advance, including the pass count and the DONE check.
    - STOP -> IDLE: Q<=0, IDX<=0, TC<=0.
  - DONE: Q/IDX/TC hold.
    - START restarts as from IDLE.
    - STOP -> IDLE: Q<=0, IDX<=0, TC<=0.
- BUSY = (RUN or PAUSE). DONE = (state == DONE). Both are registered and asserted the edge after the triggering control.
- Table writes:
  - WE in IDLE or DONE: tbl[WA] <= WD at that edge. A same-edge START reads the old value.
  - WE in RUN/PAUSE: the write is dropped and WERR=1 for one cycle.
- LEN/NCYC/DIR changes outside START edges have no effect.
- Pass counter is NW bits wide and never overflows: the maximum NCYC is 2^NW-1. In endless mode the counter saturates and is unused.
- Reset asserted mid-run: next edge yields the reset state; the table is cleared.

Decomposition:
- Package controlador_pkg:
  - state enum {IDLE, RUN, PAUSE, DONE}.
  - Default DEPTH/WIDTH constants.
  - Function computing L from LEN.
- One sub-module, tabla_secuencia: a DEPTH x WIDTH register file with synchronous clear, one write port and one combinational read port. It is driven by the controller's write enable (already qualified by state) and by the next-index read address.
- The FSM, index and pass counters live in the top module.

Test Plan:
- Reset, then write tbl = {3,7,1,9,0,0,0,0}; START with LEN=4, NCYC=2, DIR=0.
  - Q = 3,7,1,9,3,7,1,9 on consecutive cycles; TC high on each 9.
  - DONE=1 and Q holds 9 after the 8th value; BUSY=0.
- Same table, LEN=4, NCYC=1, DIR=1: Q = 9,1,7,3, then DONE with Q=3 and TC=1.
- NCYC=0, LEN=4, run 10 cycles: Q cycles 3,7,1,9 endlessly and DONE never asserts.
  - STOP while Q=1: Q stays 1 for 5 cycles.
  - STEP: Q=9, TC=1.
  - START: Q=3 on the following edge.
- WE during RUN (WA=0, WD=5): WERR pulses one cycle and tbl[0] stays 3 (verify with STOP, STOP, START: first Q=3).
- LEN=0 and LEN=12: treated as L=8, sequence wraps after index 7.
- R=1 mid-RUN with Q=7: next edge Q=0, IDX=0, BUSY=0. Table cleared, so a later START outputs Q=0 for all entries.
